dist_xbar_hs: RTL and testbench
===============================

DIST_XBAR_HS -- requirements
Module: dist_xbar_hs

Interface
REQ-001 SHALL have parameter DATA_TYPE, default 16: width of one data element in bits.
REQ-002 SHALL have parameter NUM_PES, default 4: number of output lanes (multipliers).
REQ-003 SHALL have parameter INPUT_BW, default 4: number of elements on the input bus.
REQ-004 SHALL have parameter LOG2_IN, default 2: select field width per lane, ceil(log2(INPUT_BW)), minimum 1.
REQ-005 SHALL have parameter FIFO_DEPTH, default 4: output queue depth, a power of 2 and at least 2.
REQ-006 SHALL have parameter CNT_W, default 16: width of the transfer counter.
REQ-007 SHALL have port clk, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-008 SHALL have port rst, input, 1 bit: asynchronous reset, active-low.
REQ-009 SHALL have port i_valid, input, 1 bit: upstream offers a distribution beat.
REQ-010 SHALL have port o_ready, output, 1 bit: the block can accept a beat.
REQ-011 SHALL have port i_data_bus, input, INPUT_BW*DATA_TYPE bits: source elements; element k is at bits [k*DATA_TYPE +: DATA_TYPE].
REQ-012 SHALL have port i_mux_bus, input, NUM_PES*LOG2_IN bits: per-lane source select; lane i is at bits [i*LOG2_IN +: LOG2_IN].
REQ-013 SHALL have port i_en_mask, input, NUM_PES bits: per-lane enable; a 0 bit forces that lane's data to zero.
REQ-014 SHALL have port i_clr, input, 1 bit: synchronous clear of the error flag and the transfer counter.
REQ-015 SHALL have port o_valid, output, 1 bit: the head beat is present.
REQ-016 SHALL have port i_ready, input, 1 bit: downstream accepts the head beat.
REQ-017 SHALL have port o_dist_bus, output, NUM_PES*DATA_TYPE bits: head beat lane data; lane i is at bits [i*DATA_TYPE +: DATA_TYPE].
REQ-018 SHALL have port o_mask, output, NUM_PES bits: the head beat's i_en_mask, as captured.
REQ-019 SHALL have port o_sel_err, output, 1 bit: sticky flag for an out-of-range select.
REQ-020 SHALL have port o_xfer_cnt, output, CNT_W bits: count of completed output transfers.

Function
REQ-021 SHALL define push = i_valid && o_ready and pop = o_valid && i_ready.
REQ-022 SHALL drive o_ready = (occupancy < FIFO_DEPTH), with occupancy held in a register; a push is refused when the queue is full, even if a pop occurs in the same cycle.
REQ-023 SHALL, on push, compute lane i as i_data_bus element i_mux_bus[lane i] when i_en_mask[i]=1 and the select is < INPUT_BW, otherwise zero; it SHALL write the result and i_en_mask into the queue tail.
REQ-024 SHALL, for any lane with i_en_mask[i]=1 and select >= INPUT_BW on a push, output zero for that lane and set o_sel_err; selects on masked lanes SHALL NOT set the error.
REQ-025 SHALL use a show-ahead queue: a beat pushed in cycle N appears with o_valid=1 in cycle N+1 at the earliest, and data is stable while o_valid=1 and i_ready=0.
REQ-026 SHALL drive o_dist_bus and o_mask to zero whenever o_valid=0.
REQ-027 SHALL, on simultaneous push and pop with the queue non-full, leave occupancy unchanged and preserve FIFO order.
REQ-028 SHALL wrap the read and write pointers modulo FIFO_DEPTH.
REQ-029 SHALL increment o_xfer_cnt by 1 per pop, wrapping from 2^CNT_W-1 to 0.
REQ-030 SHALL, when i_clr=1, clear o_sel_err and o_xfer_cnt on the next edge; clear SHALL take priority over a same-cycle error set or increment, and queue contents SHALL be unaffected.

Reset
REQ-031 SHALL, while rst=0, asynchronously force occupancy=0, both pointers=0, o_valid=0, o_ready=0, o_dist_bus=0, o_mask=0, o_sel_err=0 and o_xfer_cnt=0.
REQ-032 SHALL discard in-flight queue contents on reset asserted mid-operation, and SHALL assert o_ready=1 on the first clock edge after rst returns to 1.

Verification
REQ-033 SHALL verify single beat: data elements {0x0004,0x0003,0x0002,0x0001} (element 3..0), selects lanes 3..0 = {0,1,2,3}, mask 4'hF, i_ready=1 -> o_valid=1 in cycle +1 with o_dist_bus lanes 3..0 = {0x0001,0x0002,0x0003,0x0004}, then o_xfer_cnt=1.
REQ-034 SHALL verify masking and multicast: all selects=2, mask 4'b0101 -> lanes 3..0 = {0,0x0003,0,0x0003}, o_mask=4'b0101.
REQ-035 SHALL verify backpressure: i_ready=0 with 5 consecutive i_valid beats -> 4 accepted, o_ready=0 after the 4th; then i_ready=1 -> 4 beats drained in order, o_xfer_cnt=4.
REQ-036 SHALL verify the error path with INPUT_BW=3: lane 1 select=3, mask 4'hF -> lane 1=0 and o_sel_err=1 until i_clr pulses; with lane 1 masked, no error.
REQ-037 SHALL verify counter wrap and clear with CNT_W=2: 5 pops -> o_xfer_cnt=1; i_clr together with a pop -> o_xfer_cnt=0.
REQ-038 SHALL verify reset mid-operation: rst=0 with 3 beats queued -> o_valid=0 and outputs zero immediately; after release, o_ready=1 and no stale beat appears.

Source files
------------

// File: rtl/dist_xbar_hs.sv
// Distribution crossbar: routes input-bus elements to per-PE lanes through a
// show-ahead output queue with valid/ready handshakes on both sides.
module dist_xbar_hs #(
  parameter int DATA_TYPE  = 16,
  parameter int NUM_PES    = 4,
  parameter int INPUT_BW   = 4,
  parameter int LOG2_IN    = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_valid,
  output logic                          o_ready,
  input  logic [INPUT_BW*DATA_TYPE-1:0] i_data_bus,
  input  logic [NUM_PES*LOG2_IN-1:0]    i_mux_bus,
  input  logic [NUM_PES-1:0]            i_en_mask,
  input  logic                          i_clr,
  output logic                          o_valid,
  input  logic                          i_ready,
  output logic [NUM_PES*DATA_TYPE-1:0]  o_dist_bus,
  output logic [NUM_PES-1:0]            o_mask,
  output logic                          o_sel_err,
  output logic [CNT_W-1:0]              o_xfer_cnt
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int OW = PW + 1;
  localparam int LW = NUM_PES * DATA_TYPE;

  logic [PW-1:0]      r_wr_ptr;
  logic [PW-1:0]      r_rd_ptr;
  logic [OW-1:0]      r_occ;
  logic               r_ready;
  logic               r_valid;
  logic               r_sel_err;
  logic [CNT_W-1:0]   r_xfer_cnt;
  logic [LW-1:0]      r_mem_data [FIFO_DEPTH];
  logic [NUM_PES-1:0] r_mem_mask [FIFO_DEPTH];

  logic               w_push;
  logic               w_pop;
  logic [LW-1:0]      w_lanes;
  logic [NUM_PES-1:0] w_hit;
  logic               w_err;
  logic [OW-1:0]      w_occ_nxt;

  // A lane with no matching in-range select stays zero; enabled lanes without
  // a hit are exactly the out-of-range selects that raise the error.
  always_comb begin
    w_lanes = '0;
    w_hit   = '0;
    for (int unsigned i = 0; i < NUM_PES; i++) begin
      for (int unsigned k = 0; k < INPUT_BW; k++) begin
        if (i_en_mask[i] && (i_mux_bus[i*LOG2_IN +: LOG2_IN] == LOG2_IN'(k))) begin
          w_lanes[i*DATA_TYPE +: DATA_TYPE] = i_data_bus[k*DATA_TYPE +: DATA_TYPE];
          w_hit[i] = 1'b1;
        end
      end
    end
    w_err = |(i_en_mask & ~w_hit);
  end

  assign w_push    = i_valid && r_ready;
  assign w_pop     = r_valid && i_ready;
  assign w_occ_nxt = r_occ + OW'(w_push) - OW'(w_pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_occ      <= '0;
      r_ready    <= 1'b0;
      r_valid    <= 1'b0;
      r_sel_err  <= 1'b0;
      r_xfer_cnt <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_occ   <= w_occ_nxt;
      r_ready <= (w_occ_nxt < OW'(FIFO_DEPTH));
      r_valid <= (w_occ_nxt != '0);
      if (i_clr) begin
        r_sel_err  <= 1'b0;
        r_xfer_cnt <= '0;
      end else begin
        if (w_push && w_err) r_sel_err  <= 1'b1;
        if (w_pop)           r_xfer_cnt <= r_xfer_cnt + 1'b1;
      end
    end
  end

  // Storage needs no reset: entries are only visible through r_valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_data[r_wr_ptr] <= w_lanes;
      r_mem_mask[r_wr_ptr] <= i_en_mask;
    end
  end

  assign o_ready    = r_ready;
  assign o_valid    = r_valid;
  assign o_dist_bus = r_valid ? r_mem_data[r_rd_ptr] : '0;
  assign o_mask     = r_valid ? r_mem_mask[r_rd_ptr] : '0;
  assign o_sel_err  = r_sel_err;
  assign o_xfer_cnt = r_xfer_cnt;

endmodule

// File: tb/tb_dist_xbar_hs.sv
// Bench for dist_xbar_hs: a default instance and a narrow one (3 inputs, 2-bit
// counter) driven by the same stimulus, each compared against a queue model.
module tb_dist_xbar_hs;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid;
  logic [63:0] i_data_bus;
  logic [7:0]  i_mux_bus;
  logic [3:0]  i_en_mask;
  logic        i_clr;
  logic        i_ready;

  logic        a_ready, a_valid, a_err;
  logic [63:0] a_dist;
  logic [3:0]  a_mask;
  logic [15:0] a_cnt;
  logic        b_ready, b_valid, b_err;
  logic [63:0] b_dist;
  logic [3:0]  b_mask;
  logic [1:0]  b_cnt;

  int n_total = 0;
  int n_bad   = 0;

  logic [67:0] qa[$];
  logic [67:0] qb[$];
  logic        ma_err, mb_err;
  int          ma_cnt, mb_cnt;

  always #5 clk = ~clk;

  dist_xbar_hs u_a (
    .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(a_ready),
    .i_data_bus(i_data_bus), .i_mux_bus(i_mux_bus), .i_en_mask(i_en_mask),
    .i_clr(i_clr), .o_valid(a_valid), .i_ready(i_ready), .o_dist_bus(a_dist),
    .o_mask(a_mask), .o_sel_err(a_err), .o_xfer_cnt(a_cnt)
  );

  dist_xbar_hs #(.INPUT_BW(3), .LOG2_IN(2), .CNT_W(2)) u_b (
    .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(b_ready),
    .i_data_bus(i_data_bus[47:0]), .i_mux_bus(i_mux_bus), .i_en_mask(i_en_mask),
    .i_clr(i_clr), .o_valid(b_valid), .i_ready(i_ready), .o_dist_bus(b_dist),
    .o_mask(b_mask), .o_sel_err(b_err), .o_xfer_cnt(b_cnt)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] xbar(input int inbw, input logic [63:0] d,
                                       input logic [7:0] mx, input logic [3:0] mk,
                                       output logic err);
    logic [63:0] r;
    int s;
    r   = '0;
    err = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s = int'(mx[i*2 +: 2]);
      if (mk[i]) begin
        if (s < inbw) r[i*16 +: 16] = d[s*16 +: 16];
        else          err = 1'b1;
      end
    end
    return r;
  endfunction

  task automatic compare_all();
    logic [67:0] ha, hb;
    ha = (qa.size() > 0) ? qa[0] : '0;
    hb = (qb.size() > 0) ? qb[0] : '0;
    check_eq("a_ready", a_ready, qa.size() < 4);
    check_eq("a_valid", a_valid, qa.size() > 0);
    check_eq("a_dist",  a_dist,  ha[63:0]);
    check_eq("a_mask",  a_mask,  ha[67:64]);
    check_eq("a_err",   a_err,   ma_err);
    check_eq("a_cnt",   a_cnt,   ma_cnt);
    check_eq("b_ready", b_ready, qb.size() < 4);
    check_eq("b_valid", b_valid, qb.size() > 0);
    check_eq("b_dist",  b_dist,  hb[63:0]);
    check_eq("b_mask",  b_mask,  hb[67:64]);
    check_eq("b_err",   b_err,   mb_err);
    check_eq("b_cnt",   b_cnt,   mb_cnt);
  endtask

  // Checks the state left by the previous cycle, then drives one cycle.
  task automatic step(input logic v, input logic [63:0] d, input logic [7:0] mx,
                      input logic [3:0] mk, input logic clr, input logic rdy);
    logic pa, pb, ppa, ppb, ea, eb;
    logic [63:0] xa, xb;
    @(negedge clk);
    compare_all();
    i_valid = v; i_data_bus = d; i_mux_bus = mx; i_en_mask = mk; i_clr = clr; i_ready = rdy;
    xa  = xbar(4, d, mx, mk, ea);
    xb  = xbar(3, d, mx, mk, eb);
    pa  = v && (qa.size() < 4);
    pb  = v && (qb.size() < 4);
    ppa = rdy && (qa.size() > 0);
    ppb = rdy && (qb.size() > 0);
    if (ppa) void'(qa.pop_front());
    if (ppb) void'(qb.pop_front());
    if (pa) qa.push_back({mk, xa});
    if (pb) qb.push_back({mk, xb});
    if (clr) begin
      ma_err = 1'b0; mb_err = 1'b0; ma_cnt = 0; mb_cnt = 0;
    end else begin
      if (pa && ea) ma_err = 1'b1;
      if (pb && eb) mb_err = 1'b1;
      if (ppa) ma_cnt = (ma_cnt + 1) % 65536;
      if (ppb) mb_cnt = (mb_cnt + 1) % 4;
    end
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, '0, '0, '0, 1'b0, rdy);
  endtask

  task automatic model_reset();
    qa.delete(); qb.delete();
    ma_err = 1'b0; mb_err = 1'b0; ma_cnt = 0; mb_cnt = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_a_valid"}, a_valid, 1'b0);
    check_eq({tag, "_a_ready"}, a_ready, 1'b0);
    check_eq({tag, "_a_dist"},  a_dist,  64'h0);
    check_eq({tag, "_a_mask"},  a_mask,  4'h0);
    check_eq({tag, "_b_err"},   b_err,   1'b0);
    check_eq({tag, "_a_cnt"},   a_cnt,   16'h0);
    check_eq({tag, "_b_valid"}, b_valid, 1'b0);
  endtask

  localparam logic [63:0] D_SEQ = 64'h0004_0003_0002_0001;

  initial begin
    rst = 1'b0; i_valid = 1'b0; i_data_bus = '0; i_mux_bus = '0;
    i_en_mask = '0; i_clr = 1'b0; i_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_outputs("rst0");
    rst = 1'b1;

    // Single beat, reversing selects
    idle(1'b0);
    step(1'b1, D_SEQ, 8'h1B, 4'hF, 1'b0, 1'b1);
    idle(1'b1);
    check_eq("single_valid", a_valid, 1'b1);
    check_eq("single_dist",  a_dist,  64'h0001_0002_0003_0004);
    idle(1'b0);
    check_eq("single_cnt",   a_cnt,   16'd1);

    // Masking and multicast
    step(1'b1, D_SEQ, 8'hAA, 4'b0101, 1'b0, 1'b0);
    idle(1'b0);
    check_eq("mcast_dist", a_dist, 64'h0000_0003_0000_0003);
    check_eq("mcast_mask", a_mask, 4'b0101);
    idle(1'b1);

    // Backpressure: five offers, four accepted, drained in order
    step(1'b0, '0, '0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++)
      step(1'b1, {16'(i), 16'(i + 16), 16'(i + 32), 16'(i + 48)}, 8'hE4, 4'hF, 1'b0, 1'b0);
    idle(1'b0);
    check_eq("bp_ready", a_ready, 1'b0);
    for (int i = 0; i < 4; i++) begin
      idle(1'b1);
      check_eq("bp_order", a_dist[15:0], 64'(i + 48));
    end
    idle(1'b0);
    check_eq("bp_cnt", a_cnt, 16'd4);

    // Error path on narrow instance: masked out-of-range lane is harmless
    step(1'b0, '0, '0, '0, 1'b1, 1'b0);
    step(1'b1, D_SEQ, 8'h0C, 4'b1101, 1'b0, 1'b1);
    idle(1'b1);
    check_eq("err_masked", b_err, 1'b0);
    step(1'b1, D_SEQ, 8'h0C, 4'hF, 1'b0, 1'b1);
    idle(1'b1);
    check_eq("err_set", b_err, 1'b1);
    check_eq("err_lane1", b_dist[31:16], 64'h0);
    idle(1'b0);
    check_eq("err_sticky", b_err, 1'b1);
    step(1'b0, '0, '0, '0, 1'b1, 1'b0);
    idle(1'b0);
    check_eq("err_clr", b_err, 1'b0);

    // Counter wrap and clear racing a pop on the 2-bit counter
    for (int i = 0; i < 5; i++) step(1'b1, D_SEQ, 8'h00, 4'h1, 1'b0, 1'b1);
    idle(1'b1);
    idle(1'b0);
    check_eq("wrap_cnt", b_cnt, 2'd1);
    step(1'b1, D_SEQ, 8'h00, 4'h1, 1'b0, 1'b0);
    step(1'b0, '0, '0, '0, 1'b1, 1'b1);
    idle(1'b0);
    check_eq("clr_pop_cnt", b_cnt, 2'd0);

    // Randomized traffic
    for (int n = 0; n < 400; n++)
      step(1'($urandom), {$urandom, $urandom}, 8'($urandom), 4'($urandom),
           ($urandom_range(0, 19) == 0), ($urandom_range(0, 2) != 0));

    // Reset in the middle of traffic
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);
    step(1'b1, D_SEQ, 8'h1B, 4'hF, 1'b0, 1'b0);
    step(1'b1, D_SEQ, 8'hAA, 4'hF, 1'b0, 1'b0);
    step(1'b1, D_SEQ, 8'h0C, 4'hF, 1'b0, 1'b0);
    idle(1'b0);
    check_eq("pre_rst_valid", a_valid, 1'b1);
    #2 rst = 1'b0;
    #1 check_reset_outputs("midrst");
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    idle(1'b1);
    check_eq("post_rst_ready", a_ready, 1'b1);
    idle(1'b1);
    check_eq("post_rst_stale", a_valid, 1'b0);
    for (int n = 0; n < 40; n++)
      step(1'($urandom), {$urandom, $urandom}, 8'($urandom), 4'($urandom),
           1'b0, 1'($urandom));
    idle(1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
